tag_meta_array: RTL
===================

// Module: tag_meta_array
// PURPOSE
//  - Parametrised N-way set-associative tag/metadata store for the L1 caches; successor to the 2-way, 64-set tag array.
//  - Each way of each set holds {valid, tag} plus a per-set true-LRU age field.
//  - It performs hit detection, hit-way encoding and victim selection internally, so cache control no longer compares tags.
//  - It adds a sequenced invalidate-all (flush).
// PARAMETERS
//  WAYS   2   associativity; power of two, 2..8; WAY_W = $clog2(WAYS)
//  SETS   64  number of sets; power of two; SET_W = $clog2(SETS)
//  TAG_W  6   tag width in bits
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-low reset (0 = reset)
//  lk_valid      in   1      lookup request
//  lk_set        in   SET_W  lookup set index
//  lk_tag        in   TAG_W  lookup tag
//  lk_touch      in   1      on hit, mark hit way MRU
//  rsp_valid     out  1      lookup response valid (1 cycle after lk_valid)
//  rsp_hit       out  1      tag matched a valid way
//  rsp_way       out  WAY_W  hit way (0 on miss)
//  rsp_victim    out  WAY_W  replacement way for the looked-up set
//  rsp_perr      out  1      parity error detected (META_PARITY_EN only)
//  fill_valid    in   1      write {valid=1, tag} into fill_set/fill_way and make it MRU
//  fill_set      in   SET_W  fill set index
//  fill_way      in   WAY_W  fill way
//  fill_tag      in   TAG_W  fill tag
//  flush_req     in   1      pulse: invalidate all sets
//  busy          out  1      flush in progress
// BEHAVIOUR
//  - Reset (async, rst=0):
//    - All valid bits=0; age[s][w]=w for every set.
//    - rsp_valid/rsp_hit/rsp_perr/busy=0; rsp_way=rsp_victim=0.
//    - FSM=IDLE.
//  - Lookup: latency 1.
//    - rsp_* are registered from state sampled on the lk_valid edge.
//    - rsp_valid=0 on cycles without an accepted lookup; rsp_hit/rsp_way/rsp_victim hold their last value.
//  - Hit: exactly one valid way with tag==lk_tag. Multiple matches are a caller error; lowest index wins.
//  - Victim: lowest-index invalid way; if all ways are valid, the way with age==WAYS-1 (LRU).
//  - LRU update (touch of way w in set s):
//    - Every way with age < age[w] increments.
//    - age[w]=0; ages stay a permutation of 0..WAYS-1.
//    - Applied at the edge after the request cycle.
//  - Same-cycle fill and lookup to the same set:
//    - Lookup sees pre-fill contents (read-before-write).
//    - Fill's LRU update has priority over the lookup touch; the lookup touch is dropped.
//  - Different sets: both operations complete independently.
//  - Fill to an already-valid way overwrites silently.
//  - FSM:
//    - IDLE -> FLUSH on flush_req. busy=1 from the next cycle.
//    - FLUSH clears valid and resets ages of one set per cycle, counter 0..SETS-1.
//    - FLUSH -> IDLE after set SETS-1. busy=0 on the cycle after. Total SETS cycles busy.
//  - During FLUSH:
//    - lk_valid and fill_valid are ignored: no response, no write.
//    - flush_req is ignored.
//  - Reset mid-flush: async clear completes the invalidate; FSM returns to IDLE immediately.
//  - Set-counter wrap: counter is SET_W bits; terminal detection at all-ones, no overflow state.
// CONFIGURATION
//  META_PARITY_EN defined:
//    - Each way stores an even-parity bit over {valid, tag}, written on fill and on flush.
//    - On lookup, a valid way whose parity mismatches:
//      - rsp_perr=1.
//      - Treated as not matching, so it cannot produce a hit.
//      - Its valid bit is cleared at the response edge.
//  META_PARITY_EN undefined: no parity storage; rsp_perr tied 0.
// TESTING (WAYS=4, SETS=64, TAG_W=6 unless noted)
//  - Reset, then lookup set 5 tag 0x2A:
//    - rsp_valid=1 next cycle, rsp_hit=0, rsp_victim=0.
//  - Fill set 5 ways 0..3 with tags 0x10..0x13, then lookup tag 0x12 with lk_touch:
//    - hit, rsp_way=2.
//    - Next lookup of set 5 gives rsp_victim=0 (LRU).
//  - Touch ways 0,1,2,3 in order on a full set 9, then lookup set 9:
//    - rsp_victim=0.
//    - Touch 0 then look up again: rsp_victim=1.
//  - Fill set 3 way 1 tag 0x07 and lookup set 3 tag 0x07 in the same cycle:
//    - rsp_hit=0.
//    - Lookup in the following cycle: hit, way 1.
//  - Fill several sets, pulse flush_req:
//    - busy high for exactly 64 cycles.
//    - Lookups during busy give no rsp_valid.
//    - After busy falls, every lookup misses with rsp_victim=0.
//  - META_PARITY_EN: force a parity bit flip in set 2 way 3 (tag 0x15), lookup 0x15:
//    - rsp_hit=0, rsp_perr=1.
//    - Next lookup gives rsp_victim=3.

Source files
------------

// File: rtl/tag_meta_array_if.sv
// Lookup / fill / flush signal bundle shared by tag_meta_array and its cache controller.
interface tag_meta_array_if #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int TAG_W = 6
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  logic             lk_valid;
  logic [SET_W-1:0] lk_set;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_touch;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic [WAY_W-1:0] rsp_victim;
  logic             rsp_perr;
  logic             fill_valid;
  logic [SET_W-1:0] fill_set;
  logic [WAY_W-1:0] fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             flush_req;
  logic             busy;

  modport master (
    output lk_valid, lk_set, lk_tag, lk_touch,
    output fill_valid, fill_set, fill_way, fill_tag, flush_req,
    input  rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_perr, busy
  );

  modport slave (
    input  lk_valid, lk_set, lk_tag, lk_touch,
    input  fill_valid, fill_set, fill_way, fill_tag, flush_req,
    output rsp_valid, rsp_hit, rsp_way, rsp_victim, rsp_perr, busy
  );
endinterface

// File: rtl/tag_meta_array.sv
// N-way set-associative tag/valid/true-LRU store with hit, victim selection and sequenced flush.
// Optional META_PARITY_EN: per-way even parity over {valid, tag}, reported on rsp_perr.
module tag_meta_array #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  tag_meta_array_if.slave  bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  typedef logic [WAYS-1:0][WAY_W-1:0] age_t;
  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_busy, lk_acc, fill_acc;

  logic [WAYS-1:0]             set_valid [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  set_tag   [SETS];
  age_t                        set_age   [SETS];
`ifdef META_PARITY_EN
  logic [WAYS-1:0]             set_par   [SETS];
`endif

  logic [WAYS-1:0]             rd_valid;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  age_t                        rd_age;
  logic [WAYS-1:0]             match_vec, perr_vec;
  logic                        hit;
  logic [WAY_W-1:0]            hit_way, victim_way;

  logic             rsp_valid_q, rsp_hit_q, rsp_perr_q;
  logic [WAY_W-1:0] rsp_way_q, rsp_victim_q;

  function automatic age_t age_init();
    age_t a;
    for (int w = 0; w < WAYS; w++) a[w] = WAY_W'(w);
    return a;
  endfunction

  // True-LRU touch: ways younger than the touched one age by one, touched way becomes 0.
  function automatic age_t age_touch(input age_t a, input logic [WAY_W-1:0] way);
    age_t r;
    r = a;
    for (int w = 0; w < WAYS; w++)
      if (a[w] < a[way]) r[w] = a[w] + WAY_W'(1);
    r[way] = '0;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        flush_cnt_d = '0;
        if (bus.flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + SET_W'(1);
        if (flush_cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_busy = (state_q == FLUSH);
  assign lk_acc     = bus.lk_valid && !flush_busy;
  assign fill_acc   = bus.fill_valid && !flush_busy;

  assign rd_valid = set_valid[bus.lk_set];
  assign rd_tag   = set_tag[bus.lk_set];
  assign rd_age   = set_age[bus.lk_set];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
`ifdef META_PARITY_EN
    logic [WAYS-1:0] rd_par;
    assign rd_par       = set_par[bus.lk_set];
    assign perr_vec[gi] = rd_valid[gi] && (rd_par[gi] != ^{1'b1, rd_tag[gi]});
`else
    assign perr_vec[gi] = 1'b0;
`endif
    assign match_vec[gi] = rd_valid[gi] && (rd_tag[gi] == bus.lk_tag) && !perr_vec[gi];
  end

  // Downward scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    logic             any_inv;
    logic [WAY_W-1:0] inv_way, lru_way;
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match_vec[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!rd_valid[w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (rd_age[w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim_way = any_inv ? inv_way : lru_way;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_victim_q <= '0;
      rsp_perr_q   <= 1'b0;
    end else begin
      rsp_valid_q <= lk_acc;
      if (lk_acc) begin
        rsp_hit_q    <= hit;
        rsp_way_q    <= hit_way;
        rsp_victim_q <= victim_way;
        rsp_perr_q   <= |perr_vec;
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_way    = rsp_way_q;
  assign bus.rsp_victim = rsp_victim_q;
  assign bus.rsp_perr   = rsp_perr_q;
  assign bus.busy       = flush_busy;

  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    logic [WAYS-1:0]            valid_q, valid_d;
    age_t                       age_q, age_d;
    logic [WAYS-1:0][TAG_W-1:0] tag_q;
    logic                       flush_here, fill_here, lk_here;

    assign flush_here = flush_busy && (flush_cnt_q == SET_W'(gi));
    assign fill_here  = fill_acc && (bus.fill_set == SET_W'(gi));
    assign lk_here    = lk_acc && (bus.lk_set == SET_W'(gi));

    // A fill's MRU update wins over a same-set lookup touch, which is dropped.
    always_comb begin
      valid_d = valid_q;
      age_d   = age_q;
      if (flush_here) begin
        valid_d = '0;
        age_d   = age_init();
      end else begin
        if (lk_here) valid_d = valid_d & ~perr_vec;
        if (fill_here) begin
          valid_d[bus.fill_way] = 1'b1;
          age_d = age_touch(age_q, bus.fill_way);
        end else if (lk_here && bus.lk_touch && hit) begin
          age_d = age_touch(age_q, hit_way);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        age_q   <= age_init();
      end else begin
        valid_q <= valid_d;
        age_q   <= age_d;
      end
    end

    always_ff @(posedge clk) begin
      if (fill_here) tag_q[bus.fill_way] <= bus.fill_tag;
    end

    assign set_valid[gi] = valid_q;
    assign set_tag[gi]   = tag_q;
    assign set_age[gi]   = age_q;

`ifdef META_PARITY_EN
    logic [WAYS-1:0] par_q;
    always_ff @(posedge clk) begin
      if (fill_here) begin
        par_q[bus.fill_way] <= ^{1'b1, bus.fill_tag};
      end else if (flush_here) begin
        for (int w = 0; w < WAYS; w++) par_q[w] <= ^{1'b0, tag_q[w]};
      end
    end
    assign set_par[gi] = par_q;
`endif
  end

endmodule
